// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared types and constants for the register-file write arbiter slice.
//   REG_AW        : register address width (32 architectural registers)
//   XLEN          : register data width
//   rf_wr_t       : one pending register-file write {addr, data}
//   drain_state_t : forced-drain FSM state encoding
//   is_nonzero_reg: true when an address names a real register (not x0)
// ---------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  typedef enum logic [0:0] {
    DS_NORMAL = 1'b0,
    DS_FORCE  = 1'b1
  } drain_state_t;

  // x0 is hardwired to zero, so writes to it and hazards on it are void.
  function automatic logic is_nonzero_reg(input logic [REG_AW-1:0] a);
    return (a != '0);
  endfunction

endpackage

// File: rtl/rf_wq_fifo.sv
// ---------------------------------------------------------------------------
// rf_wq_fifo
// DEPTH-entry FIFO of rf_wr_t entries holding MDU results that are waiting
// for a free register-file write slot.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push         : enqueue push_data (ignored when full)
//   push_data    : entry to enqueue
//   pop          : dequeue the head (ignored when empty)
//   pop_data     : current head entry (valid when !empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rf_wq_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rf_wr_t        push_data,
  input  logic          pop,
  output rf_wr_t        pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rf_wr_t        mem_q [DEPTH];
  rf_wr_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port between pipeline writeback and
// the multiply/divide unit. MDU results are queued and drained into idle
// writeback slots; a forced-drain FSM freezes the pipeline when the queue
// head has been starved for too long. A 32-bit scoreboard of outstanding MDU
// destinations drives the decode-stage hazard stall.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   wb_we, wb_addr, wb_data         : writeback write request
//   mdu_issue, mdu_issue_addr       : MDU op leaves ID with destination rd
//   mdu_valid, mdu_addr, mdu_data   : MDU result offer
//   mdu_ready                       : result queue can accept
//   rf_we, rf_addr, rf_data         : register-file write port
//   rs1_id, rs2_id, rd_id           : decode-stage register addresses
//   sb_hazard                       : decode must stall (RAW/WAW on MDU dest)
//   stall_req                       : forced-drain pipeline freeze request
// ---------------------------------------------------------------------------
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mdu_issue,
  input  logic [REG_AW-1:0] mdu_issue_addr,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              mdu_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [XLEN-1:0]   rf_data,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  output logic              sb_hazard,
  output logic              stall_req
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  rf_wr_t        push_entry;
  rf_wr_t        head;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  logic          q_pop;
  logic          mdu_accept, mdu_push;
  logic          wb_req;
  logic          head_wins, wb_wins;

  drain_state_t  state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   sb_q, sb_d;

  // MDU handshake: a result transfers on mdu_valid && mdu_ready. mdu_ready
  // depends only on the registered occupancy, never on a same-cycle pop, so
  // a full queue refuses the offer even while its head is being written.
  assign mdu_ready  = (q_count != CW'(DEPTH));
  assign mdu_accept = mdu_valid && mdu_ready;
  // Results for x0 complete the handshake but are dropped here.
  assign mdu_push   = mdu_accept && is_nonzero_reg(mdu_addr);

  assign push_entry.addr = mdu_addr;
  assign push_entry.data = mdu_data;

  rf_wq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mdu_push && !q_full),
    .push_data(push_entry),
    .pop      (q_pop),
    .pop_data (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign stall_req = (state_q == DS_FORCE);
  // A WB write to x0 does not need the port, so it never blocks the queue.
  assign wb_req    = wb_we && is_nonzero_reg(wb_addr);

  // Port arbitration. During a forced drain the pipeline is frozen, so the
  // WB request is ignored and will be presented again next cycle.
  always_comb begin
    head_wins = 1'b0;
    wb_wins   = 1'b0;
    if (stall_req) begin
      head_wins = !q_empty;
    end else if (wb_req) begin
      wb_wins = 1'b1;
    end else begin
      head_wins = !q_empty;
    end
  end

  assign q_pop   = head_wins;
  assign rf_we   = head_wins || wb_wins;
  assign rf_addr = head_wins ? head.addr : wb_addr;
  assign rf_data = head_wins ? head.data : wb_data;

  // Forced-drain FSM. The starve counter tracks consecutive cycles in which
  // a waiting head lost the port to WB; one more loss at STARVE_MAX-1 forces
  // exactly one drain cycle.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      DS_NORMAL: begin
        if (q_empty || q_pop) begin
          starve_d = '0;
        end else if (wb_wins) begin
          if (starve_q == SW'(STARVE_MAX - 1)) begin
            state_d  = DS_FORCE;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      DS_FORCE: begin
        starve_d = '0;
        if (q_pop) begin
          state_d = DS_NORMAL;
        end
      end
      default: begin
        state_d  = DS_NORMAL;
        starve_d = '0;
      end
    endcase
  end

  // Scoreboard: the issue-side set is applied after the writeback-side
  // clear so a re-issue to the same register keeps the bit pending.
  always_comb begin
    sb_d = sb_q;
    if (q_pop && is_nonzero_reg(head.addr)) begin
      sb_d[head.addr] = 1'b0;
    end
    if (mdu_issue && is_nonzero_reg(mdu_issue_addr)) begin
      sb_d[mdu_issue_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // The rd_id term blocks WAW so WB and a queued result never target the
  // same register, which keeps the arbitration order free of write ordering.
  assign sb_hazard = (is_nonzero_reg(rs1_id) && sb_q[rs1_id]) ||
                     (is_nonzero_reg(rs2_id) && sb_q[rs2_id]) ||
                     (is_nonzero_reg(rd_id)  && sb_q[rd_id]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DS_NORMAL;
      starve_q <= '0;
      sb_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      sb_q     <= sb_d;
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between pipeline writeback and the long-latency multiply/divide unit (MDU). It buffers MDU results in a small queue and drains them into idle writeback slots. It keeps a per-register scoreboard of outstanding MDU destinations, so the decode stage can stall on RAW/WAW hazards. It sits between the WB stage, the MDU result interface and the write port of `RGBRegister`, and feeds the ID-stage stall logic.

## Interface
- `DEPTH`, 2: MDU result queue entries (≥1).
- `STARVE_MAX`, 4: consecutive lost arbitration cycles before a forced drain.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_we`, `wb_addr`, `wb_data`  in  1/5/32  writeback write request.
- `mdu_issue`, `mdu_issue_addr`  in  1/5  MDU op leaves ID with destination rd.
- `mdu_valid`, `mdu_addr`, `mdu_data`  in  1/5/32  MDU result offer.
- `mdu_ready`  out  1  queue can accept a result.
- `rf_we`, `rf_addr`, `rf_data`  out  1/5/32  to register-file write port.
- `rs1_id`, `rs2_id`, `rd_id`  in  5  decode-stage register addresses.
- `sb_hazard`  out  1  decode must stall.
- `stall_req`  out  1  forced-drain pipeline freeze request.

## Operation
- Reset values:
  - queue empty, scoreboard all 0, starve counter 0.
  - `stall_req`=0, `mdu_ready`=1, `sb_hazard`=0.
  - `rf_we` follows `wb_we` (queue is empty, so only WB can write).
- MDU handshake:
  - Accept on `mdu_valid && mdu_ready`.
  - `mdu_ready` = (count != DEPTH); it does not depend on a pop in the same cycle.
  - A result with `mdu_addr`=0 is accepted and discarded (never enqueued).
- Port arbitration, combinational each cycle:
  - When `stall_req`=1: queue head wins and `wb_we` is ignored. The pipeline is frozen, so the WB instruction is held and retries.
  - Otherwise, if `wb_we && wb_addr!=0`: WB wins.
  - Otherwise, if the queue is non-empty: head wins and is popped at the clock edge.
  - Otherwise `rf_we`=0.
  - WB writes to x0 leave the port free.
- No bypass: an accepted result reaches `rf_we` no earlier than the following cycle.
- Scoreboard (32 bits):
  - Set bit[`mdu_issue_addr`] on `mdu_issue` when the address is nonzero.
  - Clear the bit when the queue head carrying that address is written.
  - Set and clear on the same address in the same cycle: set wins.
  - A result discarded for x0 clears nothing.
- `sb_hazard` = sb[`rs1_id`] | sb[`rs2_id`] | sb[`rd_id`], with address 0 ignored (bit 0 is never set). The `rd_id` term covers WAW, so WB and the queue never target the same register.
- Forced-drain FSM:
  - States: NORMAL, FORCE.
  - NORMAL: the starve counter increments each cycle the queue is non-empty and WB wins. It clears when the head pops or the queue is empty.
  - NORMAL→FORCE when the counter reaches STARVE_MAX-1 and WB wins again. The registered `stall_req` rises the next cycle.
  - FORCE: `stall_req`=1 and the head pops. Return to NORMAL the cycle after exactly one pop; `stall_req` is then 0 and the counter is 0.
- Reset asserted mid-operation discards queued results and the scoreboard. The pipeline is reset in the same cycle.

## Timing
- Result latency from acceptance to `rf_we`: 1 cycle minimum. With the queue full and WB busy, latency is at most DEPTH·(STARVE_MAX+1) cycles.
- `sb_hazard` is combinational from the scoreboard and ID addresses. A bit clears at the edge that writes the register, so the dependent instruction leaves ID the next cycle and reads the value through the register file's write-then-read behaviour.
- Enqueue and pop in the same cycle on a full queue: the pop occurs and the enqueue is refused (`mdu_ready` was 0).
- Count width: clog2(DEPTH+1); read/write pointers wrap modulo DEPTH.

## Structure
- Shared package `rf_arb_pkg`: `REG_AW`=5, `XLEN`=32, struct `rf_wr_t` {addr, data}, FSM enum `drain_state_t`.
- One sub-module, `rf_wq_fifo`: DEPTH-entry `rf_wr_t` FIFO with push/pop/full/empty/count. The arbiter, scoreboard and FSM stay in the top module.

## Test plan
- After reset, issue x5; MDU offers x5=0xDEAD_BEEF with WB idle:
  - accepted that cycle;
  - next cycle `rf_we`=1, addr 5, data 0xDEADBEEF;
  - sb[5] clears at that edge.
- Issue x7, then ID presents rs2=7: `sb_hazard`=1 until the x7 result is written, then 0 the following cycle. Repeat with rd_id=7 (WAW).
- WB writes every cycle, DEPTH=2 queue full:
  - `mdu_ready`=0;
  - `stall_req` rises after STARVE_MAX lost cycles;
  - head written while `wb_we` is ignored;
  - `stall_req` falls after one pop.
- MDU result to x0 and WB write to x0: no `rf_we`, scoreboard unchanged, result consumed.
- Issue x9 in the same cycle the pending x9 result pops: sb[9] remains 1.
- Assert `rst_n`=0 with 2 queued entries and 3 scoreboard bits set: immediately the queue is empty, all bits are 0, `stall_req`=0 and `mdu_ready`=1.
